// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access over a req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned accesses with rsp_err.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_unsigned,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        lsu_busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic        drop_q;
    logic        accept;
    logic        misalign;
    logic        issue;
    logic        trap;
    logic        done;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign lsu_busy  = (state != IDLE);
    assign bus_req   = (state == REQ);
    assign accept    = req_valid & req_ready & ~flush;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        unique case (req_size)
            3'd0:    misalign = 1'b0;
            3'd1:    misalign = req_addr[0];
            default: misalign = |req_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign issue = accept & ~misalign;
    assign trap  = accept & misalign;
    // A flush seen during the access still lets the bus finish, but silently.
    assign done  = (state == WAIT) & bus_rvalid & ~drop_q & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ: begin
                if (bus_gnt)    state_nxt = WAIT;
                else if (flush) state_nxt = IDLE;
            end
            WAIT: if (bus_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        be_nxt    = 4'hF;
        wdata_nxt = req_wdata;
        unique case (req_size)
            3'd0: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            3'd1: begin
                be_nxt    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (off_q)
            2'd0:    lb = bus_rdata[7:0];
            2'd1:    lb = bus_rdata[15:8];
            2'd2:    lb = bus_rdata[23:16];
            default: lb = bus_rdata[31:24];
        endcase
        lh = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (size_q)
            3'd0:    load_data = {{24{~uns_q & lb[7]}}, lb};
            3'd1:    load_data = {{16{~uns_q & lh[15]}}, lh};
            default: load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            off_q     <= '0;
            drop_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done | trap;
            if (issue) begin
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_we    <= req_write;
                bus_be    <= be_nxt;
                bus_wdata <= wdata_nxt;
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                off_q     <= req_addr[1:0];
                drop_q    <= 1'b0;
            end else if (lsu_busy && flush) begin
                drop_q <= 1'b1;
            end
            if (trap || done)
                rsp_rdata <= (trap || bus_we) ? 32'h0 : load_data;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign rsp_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err_q <= 1'b0;
        else if (trap) err_q <= 1'b1;
        else if (done) err_q <= 1'b0;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        req_unsigned;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        lsu_busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .flush        (flush),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .lsu_busy     (lsu_busy),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the cycle after accept.
    task automatic send(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz,
                        input logic un);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = un;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic grant;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        bus_rvalid = 1'b1;
        bus_rdata  = d;
        tick();
        bus_rvalid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [2:0] sz, input logic un,
                        input logic [31:0] d, input logic [31:0] exp);
        send(1'b0, a, 32'h0, sz, un);
        grant();
        respond(d);
        check({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_data"}, rsp_rdata, exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        flush        = 1'b0;
        bus_gnt      = 1'b0;
        bus_rvalid   = 1'b0;
        bus_rdata    = '0;
        tick();
        tick();
        check("rst_busy", 32'(lsu_busy), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        rst_n = 1'b1;
        check("rst_ready", 32'(req_ready), 32'h1);

        // Word store, minimum latency
        send(1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 1'b0);
        check("ws_bus_req", 32'(bus_req), 32'h1);
        check("ws_addr", bus_addr, 32'h100);
        check("ws_be", 32'(bus_be), 32'hF);
        check("ws_we", 32'(bus_we), 32'h1);
        check("ws_wdata", bus_wdata, 32'hDEADBEEF);
        check("ws_ready_busy", 32'(req_ready), 32'h0);
        grant();
        check("ws_wait_req", 32'(bus_req), 32'h0);
        check("ws_c2_valid", 32'(rsp_valid), 32'h0);
        respond(32'h0);
        check("ws_c3_valid", 32'(rsp_valid), 32'h1);
        check("ws_rdata", rsp_rdata, 32'h0);
        check("ws_idle", 32'(req_ready), 32'h1);
        tick();
        check("ws_pulse", 32'(rsp_valid), 32'h0);

        // Misaligned word load
        send(1'b0, 32'h101, 32'h0, 3'd2, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_bus_req", 32'(bus_req), 32'h0);
        check("mis_busy", 32'(lsu_busy), 32'h0);
        check("mis_valid", 32'(rsp_valid), 32'h1);
        check("mis_err", 32'(rsp_err), 32'h1);
        check("mis_rdata", rsp_rdata, 32'h0);
        tick();
        check("mis_err_hold", 32'(rsp_err), 32'h1);
`else
        check("mis_bus_req", 32'(bus_req), 32'h1);
        check("mis_addr", bus_addr, 32'h100);
        check("mis_be", 32'(bus_be), 32'hF);
        grant();
        respond(32'h12345678);
        check("mis_valid", 32'(rsp_valid), 32'h1);
        check("mis_err", 32'(rsp_err), 32'h0);
        check("mis_rdata", rsp_rdata, 32'h12345678);
`endif

        // Byte and half loads, lane select and extension
        send(1'b0, 32'h203, 32'h0, 3'd0, 1'b0);
        check("lb_addr", bus_addr, 32'h200);
        check("lb_be", 32'(bus_be), 32'h8);
        check("lb_we", 32'(bus_we), 32'h0);
        grant();
        respond(32'h80112233);
        check("lb_s", rsp_rdata, 32'hFFFFFF80);
        load("lbu", 32'h203, 3'd0, 1'b1, 32'h80112233, 32'h00000080);
        load("lb1", 32'h201, 3'd0, 1'b0, 32'h80112233, 32'h00000022);
        load("lh_s", 32'h202, 3'd1, 1'b0, 32'h80112233, 32'hFFFF8011);
        load("lhu", 32'h202, 3'd1, 1'b1, 32'h80112233, 32'h00008011);
        load("lh_lo", 32'h200, 3'd1, 1'b0, 32'h80118233, 32'hFFFF8233);
        tick();
        check("hold_rdata", rsp_rdata, 32'hFFFF8233);

        // Half store, grant stalled 5 cycles
        send(1'b1, 32'h002, 32'h0000ABCD, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("hs_req", 32'(bus_req), 32'h1);
            check("hs_addr", bus_addr, 32'h0);
            check("hs_be", 32'(bus_be), 32'hC);
            check("hs_wdata", bus_wdata, 32'hABCDABCD);
            check("hs_busy", 32'(lsu_busy), 32'h1);
            tick();
        end
        check("hs_still_req", 32'(bus_req), 32'h1);
        grant();
        respond(32'hFFFFFFFF);
        check("hs_valid", 32'(rsp_valid), 32'h1);
        check("hs_rdata", rsp_rdata, 32'h0);

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fi_busy", 32'(lsu_busy), 32'h0);
        check("fi_req", 32'(bus_req), 32'h0);

        // Flush in REQ
        send(1'b0, 32'h40, 32'h0, 3'd2, 1'b0);
        check("fr_req", 32'(bus_req), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fr_req_drop", 32'(bus_req), 32'h0);
        check("fr_ready", 32'(req_ready), 32'h1);
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        check("fr_no_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("fr_no_valid2", 32'(rsp_valid), 32'h0);

        // Flush in WAIT
        send(1'b0, 32'h44, 32'h0, 3'd2, 1'b0);
        grant();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fw_busy", 32'(lsu_busy), 32'h1);
        respond(32'h55555555);
        check("fw_no_valid", 32'(rsp_valid), 32'h0);
        check("fw_idle", 32'(req_ready), 32'h1);
        check("fw_rdata_hold", rsp_rdata, 32'h0);

        // Nonzero state before reset in WAIT
        load("lw", 32'h48, 3'd2, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
        send(1'b1, 32'h3C, 32'h87654321, 3'd2, 1'b0);
        grant();
        rst_n = 1'b0;
        #1;
        check("rw_req", 32'(bus_req), 32'h0);
        check("rw_busy", 32'(lsu_busy), 32'h0);
        check("rw_rdata", rsp_rdata, 32'h0);
        check("rw_addr", bus_addr, 32'h0);
        check("rw_wdata", bus_wdata, 32'h0);
        check("rw_be_we", {27'h0, bus_we, bus_be}, 32'h0);
        check("rw_err", 32'(rsp_err), 32'h0);
        tick();
        rst_n = 1'b1;
        check("rw_ready", 32'(req_ready), 32'h1);
        respond(32'h11111111);
        check("rw_no_valid", 32'(rsp_valid), 32'h0);
        check("rw_rdata2", rsp_rdata, 32'h0);
        check("rw_ready2", 32'(req_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
